// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared types and constants for the tictactoe turn arbiter
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } xoro_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    XWIN = 2'b01,
    OWIN = 2'b10,
    DRAW = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_ISSUE,
    S_WAIT_RESP,
    S_DONE
  } arb_state_t;

  localparam logic [3:0] MAX_MOVES = 4'd9;
  localparam int         TIMER_W   = 16;

endpackage

// File: rtl/ttt_turn_timer.sv
// rtl/ttt_turn_timer.sv - loadable saturating down-counter flagging turn expiry
// A load value of zero never expires.
module ttt_turn_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // One remaining count means the current enabled cycle is the last allowed one.
  assign expire = (count_q == W'(1));

endmodule

// File: rtl/tictactoe_turn_arbiter.sv
// rtl/tictactoe_turn_arbiter.sv - turn-ordered X/O move arbiter driving the board core
// Optional idle-turn forfeit timer is built only when TTT_FORFEIT_EN is defined.
module tictactoe_turn_arbiter
  import tictactoe_pkg::*;
#(
  parameter int RESP_LAT     = 1,
  parameter int TURN_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       first_o,
  input  logic       x_req,
  input  logic [1:0] x_row,
  input  logic [1:0] x_col,
  input  logic       o_req,
  input  logic [1:0] o_row,
  input  logic [1:0] o_col,
  output logic       x_ack,
  output logic       x_rej,
  output logic       o_ack,
  output logic       o_rej,
  output logic       core_clr,
  output logic       core_valid,
  output logic [1:0] core_xoro,
  output logic [1:0] core_row,
  output logic [1:0] core_col,
  input  logic       core_err,
  input  logic [1:0] core_win,
  output logic [1:0] turn,
  output logic       game_over,
  output logic [1:0] result,
  output logic [3:0] move_cnt
);

  localparam logic [2:0] LAT_LAST = 3'(RESP_LAT - 1);

  arb_state_t state_q, state_d;
  xoro_t      turn_q, turn_d;
  result_t    result_q, result_d;
  logic [3:0] move_cnt_q, move_cnt_d, cnt_inc;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [2:0] lat_q, lat_d;
  logic       x_ack_q, x_ack_d, x_rej_q, x_rej_d;
  logic       o_ack_q, o_ack_d, o_rej_q, o_rej_d;
  logic       clr_q, clr_d;
  logic       x_turn, o_turn, mv_req, mv_bad, issue_go;
  logic [1:0] mv_row, mv_col;
  logic       timer_clr, timer_en, timer_expire;

  assign x_turn   = (turn_q == X);
  assign o_turn   = (turn_q == O);
  assign mv_req   = x_turn ? x_req : (o_turn & o_req);
  assign mv_row   = x_turn ? x_row : o_row;
  assign mv_col   = x_turn ? x_col : o_col;
  assign mv_bad   = (mv_row == 2'd3) || (mv_col == 2'd3);
  assign issue_go = (state_q == S_WAIT_MOVE) && mv_req && !mv_bad && !start;
  assign timer_en = (state_q == S_WAIT_MOVE) && !issue_go;
  assign cnt_inc  = (move_cnt_q == MAX_MOVES) ? move_cnt_q : move_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    result_d   = result_q;
    move_cnt_d = move_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    lat_d      = lat_q;
    x_ack_d    = 1'b0;
    x_rej_d    = 1'b0;
    o_ack_d    = 1'b0;
    o_rej_d    = 1'b0;
    clr_d      = 1'b0;
    timer_clr  = 1'b0;
    if (start) begin
      state_d    = S_WAIT_MOVE;
      turn_d     = first_o ? O : X;
      result_d   = NONE;
      move_cnt_d = 4'd0;
      clr_d      = 1'b1;
      timer_clr  = 1'b1;
    end else begin
      if (state_q inside {S_WAIT_MOVE, S_ISSUE, S_WAIT_RESP}) begin
        x_rej_d = x_req & ~x_turn;
        o_rej_d = o_req & ~o_turn;
      end
      case (state_q)
        S_WAIT_MOVE: begin
          if (mv_req && mv_bad) begin
            if (x_turn) x_rej_d = 1'b1;
            else        o_rej_d = 1'b1;
          end
          if (issue_go) begin
            row_d   = mv_row;
            col_d   = mv_col;
            state_d = S_ISSUE;
          end else if (timer_expire) begin
            state_d  = S_DONE;
            result_d = x_turn ? OWIN : XWIN;
            turn_d   = EMPTY;
          end
        end
        S_ISSUE: begin
          lat_d   = 3'd0;
          state_d = S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (lat_q != LAT_LAST) begin
            lat_d = lat_q + 3'd1;
          end else if (core_err) begin
            if (x_turn) x_rej_d = 1'b1;
            else        o_rej_d = 1'b1;
            state_d = S_WAIT_MOVE;
          end else begin
            if (x_turn) x_ack_d = 1'b1;
            else        o_ack_d = 1'b1;
            move_cnt_d = cnt_inc;
            if (core_win != 2'b00) begin
              state_d  = S_DONE;
              result_d = result_t'(core_win);
              turn_d   = EMPTY;
            end else if (cnt_inc == MAX_MOVES) begin
              state_d  = S_DONE;
              result_d = DRAW;
              turn_d   = EMPTY;
            end else begin
              state_d   = S_WAIT_MOVE;
              turn_d    = x_turn ? O : X;
              timer_clr = 1'b1;
            end
          end
        end
        S_DONE: begin
          x_rej_d = x_req;
          o_rej_d = o_req;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      turn_q     <= EMPTY;
      result_q   <= NONE;
      move_cnt_q <= 4'd0;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      lat_q      <= 3'd0;
      x_ack_q    <= 1'b0;
      x_rej_q    <= 1'b0;
      o_ack_q    <= 1'b0;
      o_rej_q    <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      result_q   <= result_d;
      move_cnt_q <= move_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lat_q      <= lat_d;
      x_ack_q    <= x_ack_d;
      x_rej_q    <= x_rej_d;
      o_ack_q    <= o_ack_d;
      o_rej_q    <= o_rej_d;
      clr_q      <= clr_d;
    end
  end

`ifdef TTT_FORFEIT_EN
  ttt_turn_timer #(
    .W(TIMER_W)
  ) u_turn_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .en       (timer_en),
    .load_val (TIMER_W'(TURN_TIMEOUT)),
    .expire   (timer_expire)
  );
`else
  logic unused_timer;
  assign timer_expire = 1'b0;
  assign unused_timer = timer_clr ^ timer_en ^ (TURN_TIMEOUT != 0);
`endif

  // The board core is held clear for the whole reset interval.
  assign core_clr   = clr_q | ~reset;
  assign core_valid = (state_q == S_ISSUE);
  assign core_xoro  = core_valid ? turn_q : 2'b00;
  assign core_row   = core_valid ? row_q : 2'b00;
  assign core_col   = core_valid ? col_q : 2'b00;
  assign x_ack      = x_ack_q;
  assign x_rej      = x_rej_q;
  assign o_ack      = o_ack_q;
  assign o_rej      = o_rej_q;
  assign turn       = turn_q;
  assign game_over  = (state_q == S_DONE);
  assign result     = result_q;
  assign move_cnt   = move_cnt_q;

endmodule

// File: tb/tb_tictactoe_turn_arbiter.sv
// tb/tb_tictactoe_turn_arbiter.sv - directed self-checking bench for tictactoe_turn_arbiter
// Forfeit section is active when TTT_FORFEIT_EN is defined.
module tb_tictactoe_turn_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, first_o;
  logic       x_req, o_req;
  logic [1:0] x_row, x_col, o_row, o_col;
  logic       x_ack, x_rej, o_ack, o_rej;
  logic       core_clr, core_valid;
  logic [1:0] core_xoro, core_row, core_col;
  logic       core_err;
  logic [1:0] core_win;
  logic [1:0] turn, result;
  logic       game_over;
  logic [3:0] move_cnt;
  int         n_vec = 0;
  int         n_bad = 0;

  tictactoe_turn_arbiter #(
    .RESP_LAT     (1),
    .TURN_TIMEOUT (20)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .first_o    (first_o),
    .x_req      (x_req),
    .x_row      (x_row),
    .x_col      (x_col),
    .o_req      (o_req),
    .o_row      (o_row),
    .o_col      (o_col),
    .x_ack      (x_ack),
    .x_rej      (x_rej),
    .o_ack      (o_ack),
    .o_rej      (o_rej),
    .core_clr   (core_clr),
    .core_valid (core_valid),
    .core_xoro  (core_xoro),
    .core_row   (core_row),
    .core_col   (core_col),
    .core_err   (core_err),
    .core_win   (core_win),
    .turn       (turn),
    .game_over  (game_over),
    .result     (result),
    .move_cnt   (move_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic play(input logic is_o, input logic [1:0] r, input logic [1:0] c,
                      input logic err, input logic [1:0] win, input logic both,
                      input logic [1:0] exp_turn, input logic [3:0] exp_cnt);
    logic [3:0] exp_resp;
    core_err = err;
    core_win = win;
    x_req = !is_o || both;
    o_req = is_o || both;
    x_row = r; x_col = c; o_row = r; o_col = c;
    tick();
    x_req = 1'b0;
    o_req = 1'b0;
    check("issue_valid", 16'(core_valid), 16'd1);
    check("issue_xoro", 16'(core_xoro), is_o ? 16'd2 : 16'd1);
    check("issue_rowcol", 16'({core_row, core_col}), 16'({r, c}));
    check("other_rej", 16'({x_rej, o_rej}), both ? (is_o ? 16'd2 : 16'd1) : 16'd0);
    tick();
    check("resp_quiet", 16'({x_ack, x_rej, o_ack, o_rej, core_valid}), 16'd0);
    tick();
    exp_resp = err ? (is_o ? 4'b0001 : 4'b0100) : (is_o ? 4'b0010 : 4'b1000);
    check("resp", 16'({x_ack, x_rej, o_ack, o_rej}), 16'(exp_resp));
    check("turn_after", 16'(turn), 16'(exp_turn));
    check("cnt_after", 16'(move_cnt), 16'(exp_cnt));
    check("core_idle", 16'({core_valid, core_xoro, core_row, core_col}), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_o = 1'b0;
    x_req = 1'b0; o_req = 1'b0;
    x_row = 2'd0; x_col = 2'd0; o_row = 2'd0; o_col = 2'd0;
    core_err = 1'b0; core_win = 2'b00;
    #12;
    check("rst_clr", 16'(core_clr), 16'd1);
    check("rst_outs", 16'({x_ack, x_rej, o_ack, o_rej, core_valid, core_xoro, core_row, core_col}), 16'd0);
    check("rst_state", 16'({game_over, turn, result, move_cnt}), 16'd0);
    #5 rst_n = 1'b1;
    #1;
    check("rel_clr", 16'(core_clr), 16'd0);
    tick();

    // Game A: X first, mixed rejections, X wins on the 7th accepted move
    start = 1'b1; first_o = 1'b0;
    tick();
    start = 1'b0;
    check("a_clr", 16'(core_clr), 16'd1);
    check("a_turn", 16'(turn), 16'd1);
    check("a_cnt", 16'(move_cnt), 16'd0);
    tick();
    check("a_clr_pulse", 16'(core_clr), 16'd0);
    play(1'b0, 2'd1, 2'd1, 1'b0, 2'b00, 1'b0, 2'b10, 4'd1);
    play(1'b1, 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 2'b01, 4'd2);
    o_req = 1'b1; o_row = 2'd2; o_col = 2'd2;
    tick();
    o_req = 1'b0;
    check("ooturn_rej", 16'({x_rej, o_rej, core_valid}), 16'b010);
    check("ooturn_turn", 16'(turn), 16'd1);
    tick();
    check("ooturn_pulse", 16'({o_rej, core_valid}), 16'd0);
    for (int k = 0; k < 2; k++) begin
      x_req = 1'b1;
      x_row = (k == 0) ? 2'd3 : 2'd1;
      x_col = (k == 0) ? 2'd0 : 2'd3;
      tick();
      x_req = 1'b0;
      check("badrc_rej", 16'({x_ack, x_rej, core_valid}), 16'b010);
      tick();
      check("badrc_noissue", 16'({x_rej, core_valid, turn}), 16'b0001);
    end
    play(1'b0, 2'd0, 2'd2, 1'b1, 2'b00, 1'b0, 2'b01, 4'd2);
    play(1'b0, 2'd0, 2'd2, 1'b0, 2'b00, 1'b1, 2'b10, 4'd3);
    play(1'b1, 2'd1, 2'd0, 1'b0, 2'b00, 1'b0, 2'b01, 4'd4);
    play(1'b0, 2'd2, 2'd2, 1'b0, 2'b00, 1'b0, 2'b10, 4'd5);
    play(1'b1, 2'd2, 2'd0, 1'b0, 2'b00, 1'b0, 2'b01, 4'd6);
    play(1'b0, 2'd0, 2'd1, 1'b0, 2'b01, 1'b0, 2'b00, 4'd7);
    check("win_state", 16'({game_over, result}), 16'b101);
    x_req = 1'b1; x_row = 2'd1; x_col = 2'd2;
    tick();
    x_req = 1'b0;
    check("done_rej", 16'({x_ack, x_rej, core_valid}), 16'b010);
    tick();
    check("done_hold", 16'({game_over, result, move_cnt}), 16'({1'b1, 2'b01, 4'd7}));

    // Game B: nine accepted moves, draw
    start = 1'b1; first_o = 1'b0;
    tick();
    start = 1'b0;
    check("b_start", 16'({core_clr, game_over, result, move_cnt, turn}), 16'({1'b1, 1'b0, 2'b00, 4'd0, 2'b01}));
    for (int i = 0; i < 9; i++) begin
      play(i % 2 == 1, 2'(i / 3), 2'(i % 3), 1'b0, 2'b00, 1'b0,
           (i == 8) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10), 4'(i + 1));
    end
    check("draw_state", 16'({game_over, result, move_cnt}), 16'({1'b1, 2'b11, 4'd9}));

    start = 1'b1; first_o = 1'b1;
    tick();
    start = 1'b0;
    check("c_start", 16'({core_clr, game_over, result, move_cnt, turn}), 16'({1'b1, 1'b0, 2'b00, 4'd0, 2'b10}));

    // Restart while O's move waits for the core response
    core_err = 1'b0; core_win = 2'b00;
    o_req = 1'b1; o_row = 2'd1; o_col = 2'd1;
    tick();
    o_req = 1'b0;
    check("abort_issue", 16'({core_valid, core_xoro}), 16'b110);
    tick();
    start = 1'b1; first_o = 1'b0;
    tick();
    start = 1'b0;
    check("abort_noresp", 16'({x_ack, x_rej, o_ack, o_rej}), 16'd0);
    check("abort_state", 16'({core_clr, move_cnt, turn}), 16'({1'b1, 4'd0, 2'b01}));
    tick();
    check("abort_after", 16'({x_ack, x_rej, o_ack, o_rej, core_valid, core_clr}), 16'd0);

`ifdef TTT_FORFEIT_EN
    repeat (18) tick();
    check("forfeit_early", 16'(game_over), 16'd0);
    tick();
    check("forfeit", 16'({game_over, result, turn}), 16'({1'b1, 2'b10, 2'b00}));
`else
    repeat (40) tick();
    check("no_forfeit", 16'({game_over, result, turn}), 16'({1'b0, 2'b00, 2'b01}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tictactoe_turn_arbiter.md
Name: tictactoe_turn_arbiter

Overview:
- Sequences a two-player game on the tictactoe board core.
- Arbitrates move requests from player X and player O, enforcing turn order.
- Issues one move at a time to the core, waits for the core's err/win response, then acks or rejects the requester.
- Tracks move count and the game result, and clears the core at game start.

Parameters:
- RESP_LAT, 1: cycles from the core_valid clock edge to the core_err/core_win sample point; legal range 1..7.
- TURN_TIMEOUT, 1000: cycles a player may idle on its turn before forfeiting (used only with TTT_FORFEIT_EN); 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin or restart a game
- first_o  in  1  sampled with start; 1 means O moves first
- x_req  in  1  X move request
- x_row  in  2  X move row
- x_col  in  2  X move column
- o_req  in  1  O move request
- o_row  in  2  O move row
- o_col  in  2  O move column
- x_ack  out  1  one-cycle pulse: X move accepted
- x_rej  out  1  one-cycle pulse: X move rejected
- o_ack  out  1  one-cycle pulse: O move accepted
- o_rej  out  1  one-cycle pulse: O move rejected
- core_clr  out  1  one-cycle pulse clearing the core board
- core_valid  out  1  one-cycle move strobe to the core
- core_xoro  out  2  mark to place: 01 X, 10 O
- core_row  out  2  row to the core
- core_col  out  2  column to the core
- core_err  in  1  core reports an illegal move
- core_win  in  2  core winner: 00 none, 01 X, 10 O
- turn  out  2  00 idle, 01 X to move, 10 O to move
- game_over  out  1  high while in DONE
- result  out  2  00 none, 01 X win, 10 O win, 11 draw
- move_cnt  out  4  accepted moves this game, 0..9

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - All outputs 0, except core_clr=1 while reset is low.
  - move_cnt=0, result=00, turn=00.
- State machine: IDLE, WAIT_MOVE, ISSUE, WAIT_RESP, DONE.
- start (any state, highest priority):
  - Next state WAIT_MOVE, move_cnt=0, result=00, timer cleared.
  - turn = first_o ? 10 : 01.
  - core_clr pulses in the cycle after start is sampled.
  - An in-flight move is abandoned with no ack and no rej.
- WAIT_MOVE: the current player's req is sampled at edge N.
  - If row or col is 3, the player gets rej at N+1 and the state stays WAIT_MOVE.
  - Otherwise row/col are latched and the state goes to ISSUE.
- Out-of-turn req: rej pulse to that player one cycle later; never issued to the core.
  - Applies in WAIT_MOVE, ISSUE and WAIT_RESP.
  - When both players request in the same cycle, only the current player is served.
- ISSUE: lasts exactly one cycle.
  - core_valid=1, core_xoro=turn, core_row/col=latched values.
  - Then the state goes to WAIT_RESP.
- WAIT_RESP: waits RESP_LAT cycles after the core_valid edge, then samples core_err/core_win. The decision takes effect the following cycle:
  - core_err=1: rej to the mover, turn unchanged, back to WAIT_MOVE.
  - Otherwise ack to the mover and move_cnt increments.
  - core_win≠00: DONE with result=core_win.
  - Else if move_cnt reaches 9: DONE with result=11.
  - Else turn toggles and the state returns to WAIT_MOVE.
- DONE:
  - game_over=1, turn=00, outputs held.
  - All reqs are rejected.
  - Only start leaves DONE.
- Minimum request-to-ack latency is RESP_LAT+2 cycles.
- move_cnt saturates at 9 and never wraps.
- core_row, core_col and core_xoro are 0 whenever core_valid=0.

Optional Feature:
- Macro: TTT_FORFEIT_EN.
- Defined:
  - A turn timer counts cycles in WAIT_MOVE and clears on each turn change and on start.
  - When the timer reaches TURN_TIMEOUT (nonzero), the state goes to DONE with result set to the opponent's code (01 or 10).
  - The timer pauses in ISSUE and WAIT_RESP.
  - A rejected move does not clear the timer.
- Undefined: no timer logic is present, TURN_TIMEOUT is ignored, and a game ends only by win or draw.

Decomposition:
- tictactoe_pkg holds:
  - the xoro_t enum (EMPTY=00, X=01, O=10);
  - the result_t enum (NONE, XWIN, OWIN, DRAW);
  - the arbiter state enum;
  - the constant MAX_MOVES=9.
- One sub-module, ttt_turn_timer: loadable down-counter with clear, enable and expire.
  - Instantiated only under TTT_FORFEIT_EN.

Test Plan:
- Reset, then start with first_o=0: core_clr pulses and turn=01. X requests (1,1) with RESP_LAT=1 and core_err=0 → core_valid with xoro=01 row=1 col=1, x_ack 3 cycles after req, turn=10, move_cnt=1.
- o_req with turn=01 → o_rej next cycle; core_valid stays 0 and turn is unchanged.
- X requests (3,0) → x_rej next cycle with no core_valid. Then X requests (0,2) and the core returns core_err=1 → x_rej and turn stays 01.
- Seven accepted moves, then the core returns core_win=01 → x_ack, game_over=1, result=01. A subsequent x_req gets x_rej.
- Nine accepted moves with core_win=00 → result=11, move_cnt=9. Then start with first_o=1 → move_cnt=0, turn=10, core_clr pulses.
- With TTT_FORFEIT_EN and TURN_TIMEOUT=20: X idles 20 cycles on its turn → result=10, game_over=1. Asserting start mid-WAIT_RESP aborts the move with no ack.
